// File: rtl/ysyx_22041207_lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states, funct3 values and
// the legality/alignment check used when an operation is accepted.
package ysyx_22041207_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // funct3[1:0] encodes the access size for every legal load and store.
  function automatic logic lsu_op_ok(input logic wen, input logic [2:0] funct3,
                                     input logic [2:0] off);
    logic legal;
    logic aligned;
    legal = wen ? (funct3[2] == 1'b0) : (funct3 != 3'b111);
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = (off[0] == 1'b0);
      2'b10:   aligned = (off[1:0] == 2'b00);
      default: aligned = (off == 3'b000);
    endcase
    return legal && aligned;
  endfunction

endpackage

// File: rtl/ysyx_22041207_lsu_align.sv
// Byte-lane steering: store mask/data shift and load extract with sign or
// zero extension. Purely combinational.
module ysyx_22041207_lsu_align
  import ysyx_22041207_lsu_pkg::*;
(
  input  logic        wen,
  input  logic [2:0]  funct3,
  input  logic [2:0]  off,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  wmask,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_ext
);

  logic [5:0]  sh_amt;
  logic [63:0] lane;

  assign sh_amt = {off, 3'b000};
  assign lane   = rdata >> sh_amt;

  always_comb begin
    wmask    = 8'h00;
    wdata_sh = 64'd0;
    if (wen) begin
      wdata_sh = wdata << sh_amt;
      case (funct3)
        F3_SB:   wmask = 8'h01 << off;
        F3_SH:   wmask = 8'h03 << off;
        F3_SW:   wmask = 8'h0F << off;
        F3_SD:   wmask = 8'hFF;
        default: wmask = 8'h00;
      endcase
    end
  end

  always_comb begin
    rdata_ext = 64'd0;
    case (funct3)
      F3_LB:   rdata_ext = {{56{lane[7]}}, lane[7:0]};
      F3_LH:   rdata_ext = {{48{lane[15]}}, lane[15:0]};
      F3_LW:   rdata_ext = {{32{lane[31]}}, lane[31:0]};
      F3_LD:   rdata_ext = lane;
      F3_LBU:  rdata_ext = {56'd0, lane[7:0]};
      F3_LHU:  rdata_ext = {48'd0, lane[15:0]};
      F3_LWU:  rdata_ext = {32'd0, lane[31:0]};
      default: rdata_ext = 64'd0;
    endcase
  end

endmodule

// File: rtl/ysyx_22041207_lsu.sv
// Load/store unit: one operation per handshake, aligned 64-bit memory request.
// Optional WAIT timeout enabled by defining YSYX_22041207_LSU_TIMEOUT_EN.
module ysyx_22041207_lsu
  import ysyx_22041207_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_wen,
  input  logic [2:0]  lsu_funct3,
  input  logic [63:0] lsu_addr,
  input  logic [63:0] lsu_wdata,
  output logic        lsu_done,
  output logic [63:0] ramdout,
  output logic        lsu_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_rdata
);

  lsu_state_e  state_q, state_d;
  logic        wen_q, wen_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] ramdout_q, ramdout_d;
  logic        err_q, err_d;
  logic        timeout_hit;

  logic [7:0]  al_wmask;
  logic [63:0] al_wdata;
  logic [63:0] al_rdata;

  ysyx_22041207_lsu_align u_align (
    .wen       (wen_q),
    .funct3    (funct3_q),
    .off       (addr_q[2:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rsp_rdata),
    .wmask     (al_wmask),
    .wdata_sh  (al_wdata),
    .rdata_ext (al_rdata)
  );

`ifdef YSYX_22041207_LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_WAIT) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wen_d     = wen_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ramdout_d = ramdout_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (lsu_valid) begin
          wen_d    = lsu_wen;
          funct3_d = lsu_funct3;
          addr_d   = lsu_addr;
          wdata_d  = lsu_wdata;
          if (lsu_op_ok(lsu_wen, lsu_funct3, lsu_addr[2:0])) begin
            state_d = ST_REQ;
          end else begin
            state_d   = ST_DONE;
            err_d     = 1'b1;
            ramdout_d = 64'd0;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          state_d   = ST_DONE;
          err_d     = 1'b0;
          ramdout_d = wen_q ? 64'd0 : al_rdata;
        end else if (timeout_hit) begin
          state_d   = ST_DONE;
          err_d     = 1'b1;
          ramdout_d = 64'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wen_q     <= 1'b0;
      funct3_q  <= 3'd0;
      addr_q    <= 64'd0;
      wdata_q   <= 64'd0;
      ramdout_q <= 64'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wen_q     <= wen_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ramdout_q <= ramdout_d;
      err_q     <= err_d;
    end
  end

  // Request fields are driven only in REQ so the bus is quiet otherwise.
  assign lsu_ready     = (state_q == ST_IDLE);
  assign lsu_done      = (state_q == ST_DONE);
  assign ramdout       = ramdout_q;
  assign lsu_err       = err_q;
  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_req_addr  = mem_req_valid ? {addr_q[63:3], 3'b000} : 64'd0;
  assign mem_req_wen   = mem_req_valid & wen_q;
  assign mem_req_wdata = mem_req_valid ? al_wdata : 64'd0;
  assign mem_req_wmask = mem_req_valid ? al_wmask : 8'h00;

endmodule
